// File: rtl/vga_reg_commit_ctrl.sv
// Frame-synchronous write scheduler: queues bus writes, drains them in vblank.
// Optional FRAME_LOCK_EN adds a local lock register at the all-ones address.
module vga_reg_commit_ctrl #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int VACTIVE = 480
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       chipselect,
    input  logic                       write,
    input  logic [ADDR_W-1:0]          address,
    input  logic [DATA_W-1:0]          writedata,
    output logic                       waitrequest,
    input  logic [9:0]                 vcount,
    output logic                       reg_we,
    output logic [ADDR_W-1:0]          reg_addr,
    output logic [DATA_W-1:0]          reg_wdata,
    output logic                       commit_done,
    output logic [$clog2(DEPTH):0]     pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + DATA_W;
    localparam logic [9:0] VSTART = 10'(VACTIVE);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] remaining;

    logic vblank;
    logic vblank_q;
    logic vb_rise;
    logic full;
    logic wr_req;
    logic lock_hit;
    logic lock_q;
    logic push;
    logic pop;
    logic snap;
    logic done_set;

    assign vblank      = (vcount >= VSTART);
    assign vb_rise     = vblank & ~vblank_q;
    assign full        = (count == FULL_CNT);
    assign waitrequest = full;
    assign wr_req      = chipselect & write;
    assign pending     = count;

`ifdef FRAME_LOCK_EN
    assign lock_hit = wr_req & (address == {ADDR_W{1'b1}});

    // Lock register: completes like any other write, never queued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_q <= 1'b0;
        end else if (lock_hit && !full) begin
            lock_q <= writedata[0];
        end
    end
`else
    assign lock_hit = 1'b0;
    assign lock_q   = 1'b0;
`endif

    // A full FIFO stalls the master even if a pop frees a slot this cycle.
    assign push = wr_req & ~full & ~lock_hit;

    // Remember last cycle's vblank to find the start of blanking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vblank_q <= 1'b0;
        end else begin
            vblank_q <= vblank;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {address, writedata};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and per-cycle pop/snapshot/done decisions.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        snap     = 1'b0;
        done_set = 1'b0;
        case (state)
            IDLE: begin
                if (vb_rise && !lock_q) begin
                    snap     = 1'b1;
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (!vblank) begin
                    state_nx = IDLE;
                end else if (remaining != '0) begin
                    pop = 1'b1;
                end else begin
                    done_set = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (!vblank) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Only entries present at the vblank edge belong to this frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            remaining <= '0;
        end else if (snap) begin
            remaining <= count;
        end else if (pop) begin
            remaining <= remaining - ONE;
        end
    end

    // Registered register-file port and commit pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_we      <= 1'b0;
            reg_addr    <= '0;
            reg_wdata   <= '0;
            commit_done <= 1'b0;
        end else begin
            reg_we      <= pop;
            commit_done <= done_set;
            if (pop) begin
                {reg_addr, reg_wdata} <= mem[rd_ptr];
            end
        end
    end

endmodule
